sram_bus_arbiter: RTL

SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

---
 rtl/cpu_bus_pkg.sv | 35 +++
 rtl/ot_fifo.sv | 57 +++++
 rtl/sram_bus_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU-side SRAM-like bus: source ids,
// access sizes and the memory command payload presented to the shared port.
package cpu_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_t;

  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Fetches are always full-word reads with no write data.
  function automatic mem_cmd_t inst_cmd(input logic [ADDR_W-1:0] addr);
    mem_cmd_t cmd;
    cmd.wr    = 1'b0;
    cmd.size  = SZ_WORD;
    cmd.addr  = addr;
    cmd.wdata = '0;
    return cmd;
  endfunction

endpackage

// File: rtl/ot_fifo.sv
// Small FIFO tracking which source owns each outstanding memory transaction,
// so responses can be steered back in acceptance order.
module ot_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Pop on empty is dropped; push on full is allowed only alongside a pop.
  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != CNT_W'(DEPTH)) || w_pop);

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one shared
// SRAM-like memory port and routes in-order responses back to their source.
module sram_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned OT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  src_t     r_last_grant;
  src_t     r_lock_src;
  logic     r_lock;

  src_t     w_sel;
  src_t     w_head_src;
  logic     w_lock_live;
  logic     w_ot_full;
  logic     w_ot_empty;
  logic     w_mem_req;
  logic     w_hs;
  logic     w_pop;
  logic     w_head;
  mem_cmd_t w_cmd;

  // A lock only holds while its owner keeps requesting; otherwise arbitrate afresh.
  assign w_lock_live = r_lock && ((r_lock_src == SRC_INST) ? inst_req : data_req);

  always_comb begin
    w_sel = SRC_INST;
    if (w_lock_live) begin
      w_sel = r_lock_src;
    end else if (inst_req && data_req) begin
      w_sel = (r_last_grant == SRC_DATA) ? SRC_INST : SRC_DATA;
    end else if (data_req) begin
      w_sel = SRC_DATA;
    end
  end

  always_comb begin
    w_cmd = inst_cmd(inst_addr);
    if (w_sel == SRC_DATA) begin
      w_cmd.wr    = data_wr;
      w_cmd.size  = data_size;
      w_cmd.addr  = data_addr;
      w_cmd.wdata = data_wdata;
    end
  end

  // Full is taken from the registered occupancy: a response in this cycle
  // does not open a slot until the next one.
  assign w_mem_req = !reset && (inst_req || data_req) && !w_ot_full;
  assign w_hs      = w_mem_req && mem_addr_ok;
  assign w_pop     = !reset && mem_data_ok && !w_ot_empty;
  assign w_head_src = src_t'(w_head);

  assign mem_req   = w_mem_req;
  assign mem_wr    = w_cmd.wr;
  assign mem_size  = w_cmd.size;
  assign mem_addr  = w_cmd.addr;
  assign mem_wdata = w_cmd.wdata;

  assign inst_addr_ok = w_hs && (w_sel == SRC_INST);
  assign data_addr_ok = w_hs && (w_sel == SRC_DATA);
  assign inst_data_ok = w_pop && (w_head_src == SRC_INST);
  assign data_data_ok = w_pop && (w_head_src == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  ot_fifo #(
    .WIDTH (1),
    .DEPTH (OT_DEPTH)
  ) u_ot_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_hs),
    .pop   (w_pop),
    .din   (1'(w_sel)),
    .full  (w_ot_full),
    .empty (w_ot_empty),
    .head  (w_head)
  );

  // Lock the shown source while the memory stalls; any handshake or idle cycle releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock       <= 1'b0;
      r_lock_src   <= SRC_INST;
      r_last_grant <= SRC_INST;
    end else begin
      r_lock     <= w_mem_req && !mem_addr_ok;
      r_lock_src <= w_sel;
      if (w_hs) begin
        r_last_grant <= w_sel;
      end
    end
  end

endmodule
